// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch arbiter.
// Imported by the arbiter top and its round-robin picker.
package fetch_pkg;

  localparam int NUM_CORES_D = 8;
  localparam int ADDR_W_D    = 32;
  localparam int DATA_W_D    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotate requests by the pointer,
// take the lowest set bit, rotate the one-hot back.
module rr_pick
  import fetch_pkg::*;
#(
  parameter int N  = NUM_CORES_D,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  logic [N-1:0]  rot;
  logic [N-1:0]  oh_r;
  logic [PW-1:0] off;
  logic [PW-1:0] k;

  always_comb begin
    rot   = '0;
    oh_r  = '0;
    off   = '0;
    k     = '0;
    gnt_o = '0;
    any_o = |req_i;
    // index arithmetic wraps mod N because N is a power of two
    for (int i = 0; i < N; i++) begin
      k      = PW'(i) + ptr_i;
      rot[i] = req_i[k];
    end
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) off = PW'(i);
    if (any_o) oh_r = N'(1) << off;
    for (int i = 0; i < N; i++) begin
      k        = PW'(i) + ptr_i;
      gnt_o[k] = oh_r[i];
    end
    idx_o = off + ptr_i;
  end

endmodule

// File: rtl/fetch_arbiter.sv
// Round-robin sharing of one instruction-memory read port
// among several cores: grant, memory handshake, delivery.
module fetch_arbiter
  import fetch_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_D,
  parameter int ADDR_W    = ADDR_W_D,
  parameter int DATA_W    = DATA_W_D
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic [NUM_CORES-1:0]        Core_Req,
  input  logic [NUM_CORES*ADDR_W-1:0] Core_Addr,
  output logic [NUM_CORES-1:0]        Core_Grant,
  output logic [NUM_CORES-1:0]        Core_Valid,
  output logic [DATA_W-1:0]           Core_Inst,
  output logic                        Mem_Req,
  output logic [ADDR_W-1:0]           Mem_Addr,
  input  logic                        Mem_Ready,
  input  logic [DATA_W-1:0]           Mem_Data,
  output logic                        Busy
);

  localparam int PW = clog2(NUM_CORES);

  state_e                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         gidx_q, gidx_d;
  logic [NUM_CORES-1:0]  grant_q, grant_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     inst_q, inst_d;
  logic [NUM_CORES-1:0]  pick_gnt;
  logic [PW-1:0]         pick_idx;
  logic                  any_req;

  rr_pick #(
    .N  (NUM_CORES),
    .PW (PW)
  ) u_pick (
    .req_i (Core_Req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (any_req)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ISSUE;
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          addr_d  = Core_Addr[pick_idx*ADDR_W +: ADDR_W];
        end
      end
      ISSUE: begin
        if (Mem_Ready) begin
          inst_d  = Mem_Data;
          state_d = RESP;
        end
      end
      RESP: begin
        // the winner drops to lowest priority for the next pick
        ptr_d   = gidx_q + PW'(1);
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
    end
  end

  assign Core_Grant = grant_q;
  assign Core_Valid = (state_q == RESP) ? grant_q : '0;
  assign Core_Inst  = inst_q;
  assign Mem_Req    = (state_q == ISSUE);
  assign Mem_Addr   = addr_q;
  assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_arbiter.sv
// Scoreboard bench for fetch_arbiter: a transaction-level
// model predicts grants and deliveries, a monitor compares.
module tb_fetch_arbiter;

  localparam int N  = 8;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            Clk = 1'b0;
  logic            Reset_n;
  logic [N-1:0]    req_drv;
  logic [N*AW-1:0] addr_drv;
  logic [N-1:0]    Core_Grant;
  logic [N-1:0]    Core_Valid;
  logic [DW-1:0]   Core_Inst;
  logic            Mem_Req;
  logic [AW-1:0]   Mem_Addr;
  logic            Mem_Ready;
  logic [DW-1:0]   Mem_Data;
  logic            Busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit rnd      = 1'b0;
  bit rnd_mem  = 1'b0;
  bit keep_all = 1'b0;

  typedef struct {
    int          core;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t gq[$];
  exp_t vq[$];

  fetch_arbiter #(
    .NUM_CORES (N),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Core_Req   (req_drv),
    .Core_Addr  (addr_drv),
    .Core_Grant (Core_Grant),
    .Core_Valid (Core_Valid),
    .Core_Inst  (Core_Inst),
    .Mem_Req    (Mem_Req),
    .Mem_Addr   (Mem_Addr),
    .Mem_Ready  (Mem_Ready),
    .Mem_Data   (Mem_Data),
    .Busy       (Busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: each fetch is a transaction; the winner is the
  // first requester at or after the pointer, modulo N.
  initial begin
    int   mptr;
    int   w;
    bit   abort;
    mptr = 0;
    forever begin
      @(posedge Clk);
      if (!Reset_n) begin
        mptr = 0;
      end else if (req_drv != '0) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req_drv[(mptr + k) % N]) w = (mptr + k) % N;
        gq.push_back('{core: w, val: addr_drv[w*AW +: AW], cyc: cyc + 1});
        abort = 1'b0;
        do begin
          @(posedge Clk);
          if (!Reset_n) abort = 1'b1;
        end while (!abort && !Mem_Ready);
        if (abort) begin
          mptr = 0;
        end else begin
          vq.push_back('{core: w, val: Mem_Data, cyc: cyc + 1});
          @(posedge Clk);
          mptr = Reset_n ? (w + 1) % N : 0;
        end
      end
    end
  end

  // Monitor: compares whatever the DUT presents with the queues.
  initial begin
    logic [N-1:0] pg;
    exp_t         e;
    exp_t         cur;
    pg  = '0;
    cur = '{core: 0, val: 0, cyc: 0};
    forever begin
      @(negedge Clk);
      if (Reset_n) begin
        if (Core_Grant != '0 && pg == '0) begin
          if (gq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL grant_spurious: got %0h required 0", Core_Grant);
          end else begin
            e   = gq.pop_front();
            cur = e;
            chk("grant_onehot", Core_Grant, 64'(1) << e.core);
            chk("grant_addr", Mem_Addr, e.val);
            chk("grant_cycle", cyc, e.cyc);
            chk("grant_memreq", Mem_Req, 1);
            chk("grant_busy", Busy, 1);
          end
        end else if (Core_Grant != '0) begin
          chk("hold_grant", Core_Grant, 64'(1) << cur.core);
          chk("hold_addr", Mem_Addr, cur.val);
        end
        if (Core_Valid != '0) begin
          if (vq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL valid_spurious: got %0h required 0", Core_Valid);
          end else begin
            e = vq.pop_front();
            chk("valid_onehot", Core_Valid, 64'(1) << e.core);
            chk("valid_inst", Core_Inst, e.val);
            chk("valid_cycle", cyc, e.cyc);
            chk("valid_memreq", Mem_Req, 0);
          end
        end else if ((Core_Grant & ~req_drv) != '0) begin
          $display("WARN protocol: request dropped while granted %0h", Core_Grant);
        end
      end
      pg = Core_Grant;
    end
  end

  task automatic step();
    @(negedge Clk);
    for (int i = 0; i < N; i++) begin
      if (Core_Valid[i]) begin
        if (keep_all || (rnd && $urandom_range(0, 1) == 0)) begin
          if (rnd) addr_drv[i*AW +: AW] = $urandom;
        end else begin
          req_drv[i] = 1'b0;
        end
      end else if (rnd && !req_drv[i] && $urandom_range(0, 3) == 0) begin
        req_drv[i]            = 1'b1;
        addr_drv[i*AW +: AW]  = $urandom;
      end
    end
    if (rnd_mem) begin
      Mem_Ready = ($urandom_range(0, 2) == 0);
      Mem_Data  = $urandom;
    end
  endtask

  task automatic serve(input int c, input int n);
    req_drv[c]           = 1'b1;
    addr_drv[c*AW +: AW] = 32'h0000_1000 + 32'(c * 16);
    Mem_Ready            = 1'b1;
    Mem_Data             = 32'hC0DE_0000 | 32'(c);
    repeat (n) step();
  endtask

  initial begin
    Reset_n   = 1'b0;
    req_drv   = '0;
    addr_drv  = '0;
    Mem_Ready = 1'b0;
    Mem_Data  = '0;
    repeat (3) step();
    #1;
    chk("rst_grant", Core_Grant, 0);
    chk("rst_valid", Core_Valid, 0);
    chk("rst_inst", Core_Inst, 0);
    chk("rst_memreq", Mem_Req, 0);
    chk("rst_memaddr", Mem_Addr, 0);
    chk("rst_busy", Busy, 0);
    Reset_n = 1'b1;

    // single requester, memory always ready
    req_drv[2]        = 1'b1;
    addr_drv[2*AW +: AW] = 32'h0000_0040;
    Mem_Ready         = 1'b1;
    Mem_Data          = 32'h1234_5678;
    repeat (6) step();

    // pointer now past core 2: core 3 beats core 1
    req_drv[1] = 1'b1;
    req_drv[3] = 1'b1;
    addr_drv[1*AW +: AW] = 32'h0000_0110;
    addr_drv[3*AW +: AW] = 32'h0000_0330;
    repeat (10) step();

    // all cores continuously, zero wait states
    for (int i = 0; i < N; i++) addr_drv[i*AW +: AW] = 32'h0000_2000 + 32'(i * 4);
    req_drv  = '1;
    keep_all = 1'b1;
    for (int t = 0; t < 30; t++) begin
      Mem_Data = $urandom;
      step();
    end
    keep_all = 1'b0;
    repeat (30) step();

    // five wait states
    Mem_Ready  = 1'b0;
    req_drv[5] = 1'b1;
    addr_drv[5*AW +: AW] = 32'h0000_5550;
    repeat (6) step();
    Mem_Ready = 1'b1;
    Mem_Data  = 32'hA5A5_0005;
    step();
    Mem_Ready = 1'b0;
    repeat (4) step();

    // reset while waiting on memory
    req_drv[1] = 1'b1;
    addr_drv[1*AW +: AW] = 32'h0000_0999;
    repeat (3) step();
    #2;
    Reset_n = 1'b0;
    req_drv = '0;
    #1;
    chk("midrst_grant", Core_Grant, 0);
    chk("midrst_valid", Core_Valid, 0);
    chk("midrst_inst", Core_Inst, 0);
    chk("midrst_memreq", Mem_Req, 0);
    chk("midrst_memaddr", Mem_Addr, 0);
    chk("midrst_busy", Busy, 0);
    repeat (2) step();
    Reset_n   = 1'b1;
    Mem_Ready = 1'b1;
    repeat (4) step();
    chk("late_ready_idle", Busy, 0);

    // pointer fairness and wrap
    serve(5, 6);
    req_drv[0] = 1'b1;
    addr_drv[0*AW +: AW] = 32'h0000_00A0;
    serve(6, 10);
    serve(6, 6);
    serve(7, 6);
    serve(0, 6);

    // randomized traffic
    rnd     = 1'b1;
    rnd_mem = 1'b1;
    repeat (800) step();
    rnd = 1'b0;
    for (int t = 0; t < 600 && req_drv != '0; t++) step();
    chk("drain_done", req_drv, 0);
    repeat (6) step();
    chk("grant_queue_empty", gq.size(), 0);
    chk("valid_queue_empty", vq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_arbiter.md
Name: fetch_arbiter

Overview:
- Shares one instruction-memory read port among NUM_CORES cores using round-robin arbitration.
- Sequences each fetch as grant, then memory handshake, then single-cycle delivery back to the winning core.
- Core_Valid[i] is the per-core PC advance strobe and drives that core's ProgramCounter PC_en.
- Sits between the per-core PC/fetch stage and the shared instruction memory.

Parameters:
- NUM_CORES, 8, number of requesting cores (power of two, 2..16).
- ADDR_W, 32, fetch address width.
- DATA_W, 32, instruction word width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Core_Req  in  NUM_CORES  per-core fetch request, level; held until that core's Core_Valid.
- Core_Addr  in  NUM_CORES*ADDR_W  per-core fetch address (core i at bits [i*ADDR_W +: ADDR_W]).
- Core_Grant  out  NUM_CORES  one-hot owner of the in-flight transaction; all zero when idle.
- Core_Valid  out  NUM_CORES  one-cycle pulse to the owner when Core_Inst is valid; used as PC_en.
- Core_Inst  out  DATA_W  fetched instruction, broadcast to all cores, qualified by Core_Valid.
- Mem_Req  out  1  memory read request.
- Mem_Addr  out  ADDR_W  memory read address, stable while Mem_Req=1.
- Mem_Ready  in  1  memory completion; Mem_Data is valid in the same cycle.
- Mem_Data  in  DATA_W  memory read data.
- Busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (Reset_n=0, async): state=IDLE, rr_ptr=0, Core_Grant=0, Core_Valid=0, Core_Inst=0, Mem_Req=0, Mem_Addr=0, Busy=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any Core_Req is high, select the first requester searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ... mod NUM_CORES).
  - At the clock edge: register the one-hot grant in Core_Grant, latch that core's address into Mem_Addr, go to ISSUE.
  - If no Core_Req is high, stay in IDLE.
- ISSUE:
  - Mem_Req=1, with Mem_Addr and Core_Grant held.
  - If Mem_Ready=1 at an edge, latch Mem_Data into Core_Inst and go to RESP.
  - Otherwise stay in ISSUE. Wait states are unbounded; there is no timeout.
- RESP:
  - Mem_Req=0. Core_Valid[g]=1 for exactly this one cycle, where g is the granted index.
  - At the edge: rr_ptr=(g+1) mod NUM_CORES, Core_Grant cleared, go to IDLE.
- Latency and throughput:
  - Request visible at edge E0, Mem_Ready high in the first ISSUE cycle: Core_Valid is high between E1 and E2.
  - Minimum 3 cycles per fetch. Peak throughput is 1 fetch per 3 cycles.
- Core_Inst holds its last value outside RESP. Core_Valid is 0 outside RESP.
- Mem_Addr is sampled from Core_Addr only at grant. Changes on Core_Addr during ISSUE are ignored.
- Core_Req dropped while that core is granted: the transaction still completes and Core_Valid still pulses. The protocol forbids this; the bench flags it as a protocol warning.
- The winning core keeps Core_Req high during RESP: it is eligible in the next IDLE, but rr_ptr has already moved past it. This guarantees every requester is served within NUM_CORES transactions.
- Mem_Ready while in IDLE or RESP is ignored.
- Reset asserted mid-ISSUE or mid-RESP:
  - Immediate return to reset values. The fetch is aborted and no Core_Valid is issued.
  - A Mem_Ready arriving after reset release is ignored.
- rr_ptr width is clog2(NUM_CORES) and wraps naturally.

Decomposition:
- Shared package fetch_pkg:
  - state enum (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2).
  - Default NUM_CORES, ADDR_W, DATA_W constants.
  - clog2 helper.
- One sub-module: rr_pick.
  - Combinational. Inputs: request vector and rr_ptr.
  - Outputs: one-hot grant, binary index, any_req.
  - Implemented by rotate, priority-encode, rotate back.
- The FSM, address/data registers and pointer stay in fetch_arbiter.

Test Plan:
- Single requester: Core_Req=8'h04, Core_Addr[2]=32'h0000_0040, Mem_Ready tied 1 -> Mem_Addr=0x40 for one cycle, Core_Valid=8'h04 one cycle later, Core_Inst=Mem_Data, rr_ptr=3.
- All eight request continuously, zero wait states -> grant order 0,1,2,...,7,0; one Core_Valid pulse every 3 cycles; no core starved.
- Wait states: Mem_Ready delayed 5 cycles -> Mem_Req stays 1 and Mem_Addr/Core_Grant stay stable for 6 cycles; exactly one Core_Valid pulse follows.
- Pointer fairness: rr_ptr=6, Core_Req=8'h41 -> core 6 served first, then core 0 (core 6 deasserts after its Valid).
- Reset mid-ISSUE: drop Reset_n during the wait -> all outputs 0 asynchronously, rr_ptr=0; after release, a late Mem_Ready produces no Core_Valid.
- Request wrap: rr_ptr=7, Core_Req=8'h80 then 8'h01 -> core 7 served, rr_ptr wraps to 0, then core 0 served.
